// File: rtl/sram_rd_pkg.sv
// Shared defaults and FSM state encoding for the SRAM burst read master.
package sram_rd_pkg;

  localparam int unsigned DEF_ADDR_W = 20;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// First-word fall-through return buffer; extra pointer bit separates full from empty.
module sram_rd_fifo
  import sram_rd_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_c,
  output logic              valid,
  output logic              full_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr, wptr_nx, rptr_nx;
  logic              do_push, do_pop;

  // A push into a full buffer is only taken when a pop frees the slot in the same cycle
  always_comb begin
    full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop  = pop && valid;
    do_push = push && (!full_c || do_pop);
    wptr_nx = wptr + PW'(do_push);
    rptr_nx = rptr + PW'(do_pop);
    head_c  = mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      wptr  <= wptr_nx;
      rptr  <= rptr_nx;
      valid <= (wptr_nx != rptr_nx);
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Avalon-MM burst read master: pipelined single-word reads, credit-limited,
// returned on a valid/ready stream through a small FWFT buffer.
module sram_burst_reader
  import sram_rd_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [1:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, base_nx, addr_nx;
  logic [LEN_W-1:0]  len_q, len_nx, issued, issued_nx, popped, popped_nx;
  logic [CRED_W-1:0] credits, credits_nx;
  logic              start_ok, hs, push, full_c;
  logic              rd_nx, done_nx, busy_nx, overflow_nx;

  assign avm_byteenable = 2'b11;
  assign avm_write      = 1'b0;
  assign avm_writedata  = '0;

  sram_rd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (avm_readdata),
    .pop       (out_ready),
    .head_c    (out_data),
    .valid     (out_valid),
    .full_c    (full_c)
  );

  // Next-state and registered-output decode; avm_read reflects the read issued this cycle
  always_comb begin
    state_nx    = state;
    base_nx     = base_q;
    len_nx      = len_q;
    done_nx     = 1'b0;
    hs          = out_valid && out_ready;
    start_ok    = (state == IDLE) && start && !busy;
    issued_nx   = issued + LEN_W'(avm_read);
    popped_nx   = popped + LEN_W'(hs);
    push        = avm_readdatavalid && (state != IDLE);
    overflow_nx = overflow || (avm_readdatavalid && full_c && !hs);

    case (state)
      IDLE: begin
        if (start_ok) begin
          if (length == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx  = ISSUE;
            base_nx   = base_addr;
            len_nx    = length;
            issued_nx = '0;
            popped_nx = '0;
          end
        end
      end
      ISSUE: if (issued_nx == len_q) state_nx = DRAIN;
      DRAIN: begin
        if (hs && (popped_nx == len_q)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Credits bound in-flight reads plus buffered words to the buffer depth
    case ({avm_read, hs})
      2'b10:   credits_nx = credits - CRED_W'(1);
      2'b01:   credits_nx = credits + CRED_W'(1);
      default: credits_nx = credits;
    endcase

    rd_nx   = (state_nx == ISSUE) && (credits_nx != '0) && (issued_nx < len_nx);
    addr_nx = rd_nx ? (base_nx + ADDR_W'(issued_nx)) : avm_address;
    busy_nx = (state_nx != IDLE) || done_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued      <= '0;
      popped      <= '0;
      credits     <= CRED_W'(FIFO_DEPTH);
      avm_read    <= 1'b0;
      avm_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      base_q      <= base_nx;
      len_q       <= len_nx;
      issued      <= issued_nx;
      popped      <= popped_nx;
      credits     <= credits_nx;
      avm_read    <= rd_nx;
      avm_address <= addr_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      overflow    <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with an in-order SRAM controller model and
// address/data scoreboards filled at command time and drained as the DUT responds.
module tb_sram_burst_reader;

  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LEN_W      = 20;
  localparam int unsigned FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done, avm_read, avm_write, out_valid, overflow;
  logic [ADDR_W-1:0] avm_address;
  logic [1:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata, out_data;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              out_ready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int lat      = 2;
  int cyc      = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } rd_t;
  rd_t pend[$];

  sram_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: fixed latency, in order; keeps returning in-flight words across reset
  always @(negedge clk) begin : model
    rd_t r;
    cyc++;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'hDEAD;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(r.addr);
    end
    if (avm_read && !reset) pend.push_back('{cyc + lat, avm_address});
  end

  // Output monitor: address and data scoreboards, stall stability, done pulse count
  logic              stalled = 1'b0;
  logic [DATA_W-1:0] stalled_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (avm_read) begin
        check("read_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) check("read_addr", 32'(avm_address), 32'(exp_addr_q.pop_front()));
      end
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stalled_data));
      end
      if (out_valid && out_ready) begin
        check("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      stalled      = out_valid && !out_ready;
      stalled_data = out_data;
      if (done) n_done++;
    end
  end

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(ADDR_W'(b + ADDR_W'(i)));
      exp_q.push_back(mem_word(ADDR_W'(b + ADDR_W'(i))));
    end
    base_addr = b;
    length    = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_with_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic end_test(input string tag, input int done_base);
    check({tag, "_addrs_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_done_count"}, 32'(n_done - done_base), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    check({tag, "_avm_address"}, 32'(avm_address), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int done_base;
    int nrd;
    int k;

    #1;
    check_reset_values("por");
    check("byteenable", 32'(avm_byteenable), 32'd3);
    check("write_tie", 32'(avm_write), 32'd0);
    check("writedata_tie", 32'(avm_writedata), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic: four back-to-back reads from 0x10
    done_base = n_done;
    start_xfer(20'h00010, 20'd4);
    for (int i = 0; i < 4; i++) begin
      check("basic_read_burst", 32'(avm_read), 32'd1);
      @(posedge clk); #1;
    end
    check("basic_read_stop", 32'(avm_read), 32'd0);
    wait_done(50);
    end_test("basic", done_base);

    // Address wrap past the top of the space
    done_base = n_done;
    start_xfer(20'hFFFFE, 20'd4);
    check("wrap_addr0", 32'(avm_address), 32'h000FFFFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wrap_addr2", 32'(avm_address), 32'h00000000);
    wait_done(50);
    end_test("wrap", done_base);

    // Backpressure: stalled consumer limits reads to the buffer depth
    done_base = n_done;
    out_ready = 1'b0;
    start_xfer(20'h00300, 20'd20);
    nrd = 0;
    repeat (30) begin
      if (avm_read) nrd++;
      @(posedge clk); #1;
    end
    check("bp_reads_issued", 32'(nrd), 32'(FIFO_DEPTH));
    check("bp_read_idle", 32'(avm_read), 32'd0);
    check("bp_valid_stalled", 32'(out_valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    wait_done(200);
    end_test("bp", done_base);

    // Zero length: immediate done with busy, no reads
    done_base = n_done;
    base_addr = 20'h00777;
    length    = '0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("zero_done_low", 32'(done), 32'd0);
    check("zero_busy_low", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    end_test("zero", done_base);

    // Second start during a transfer is ignored
    done_base = n_done;
    start_xfer(20'h00100, 20'd10);
    repeat (3) @(posedge clk);
    #1;
    check("sb_busy", 32'(busy), 32'd1);
    base_addr = 20'h00500;
    length    = 20'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    repeat (15) @(posedge clk);
    #1;
    end_test("sb", done_base);

    // Reset mid-transfer with returns still in flight
    lat       = 6;
    done_base = n_done;
    start_xfer(20'h00040, 20'd10);
    k = 0;
    while (exp_q.size() > 7 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_three_words", 32'(exp_q.size()), 32'd7);
    check("rst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("rst_async");
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    check_reset_values("rst_held");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_stale_discarded", 32'(out_valid), 32'd0);
    check("rst_no_done", 32'(n_done - done_base), 32'd0);
    lat       = 2;
    done_base = n_done;
    start_xfer(20'h00020, 20'd2);
    wait_done(50);
    end_test("rst_new", done_base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
